// File: rtl/iob_ibex_obi2axi_bridge.sv
// Ibex request/grant/rvalid to AXI4 single-beat bridge with in-order responses and MAX_OUTST outstanding.
// Optional macro IOB_IBEX_BRIDGE_INTG_EN drives rdata_intg_o with inverted SECDED(39,32) check bits.
module iob_ibex_obi2axi_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned AXI_ID_W  = 1,
    parameter int unsigned AXI_ID    = 0,
    parameter int unsigned MAX_OUTST = 2,
    parameter bit          READ_ONLY = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [ADDR_W-3:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [6:0]            rdata_intg_o,
    output logic                  err_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [ADDR_W-3:0]     axi_awaddr_o,
    output logic [AXI_ID_W-1:0]   axi_awid_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    output logic [DATA_W-1:0]     axi_wdata_o,
    output logic [DATA_W/8-1:0]   axi_wstrb_o,
    output logic                  axi_wlast_o,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    input  logic [1:0]            axi_bresp_i,
    input  logic [AXI_ID_W-1:0]   axi_bid_i,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [ADDR_W-3:0]     axi_araddr_o,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic [DATA_W-1:0]     axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic [AXI_ID_W-1:0]   axi_rid_i,
    input  logic                  axi_rlast_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(MAX_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MAX_OUTST-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                 rvalid_q, rvalid_d, err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic full, empty, head_wr, is_wr;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs, wr_gnt, push, pop;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign head_wr = fifo_q[rptr_q];
    assign is_wr = we_i & ~READ_ONLY;

    // Request channels are combinational from the held Ibex request
    assign axi_arvalid_o = req_i & ~is_wr & ~full;
    assign axi_awvalid_o = req_i & is_wr & ~full & ~aw_done_q;
    assign axi_wvalid_o  = req_i & is_wr & ~full & ~w_done_q;
    assign axi_wlast_o   = axi_wvalid_o;
    assign axi_wstrb_o   = be_i;
    assign axi_wdata_o   = wdata_i;
    assign axi_awaddr_o  = addr_i;
    assign axi_araddr_o  = addr_i;
    assign axi_awid_o    = AXI_ID_W'(AXI_ID);
    assign axi_arid_o    = AXI_ID_W'(AXI_ID);

    // Only the channel matching the oldest outstanding transaction may retire
    assign axi_rready_o = ~empty & ~head_wr;
    assign axi_bready_o = ~empty & head_wr & ~READ_ONLY;

    assign ar_hs  = axi_arvalid_o & axi_arready_i;
    assign aw_hs  = axi_awvalid_o & axi_awready_i;
    assign w_hs   = axi_wvalid_o & axi_wready_i;
    assign r_hs   = axi_rvalid_i & axi_rready_o;
    assign b_hs   = axi_bvalid_i & axi_bready_o;
    assign wr_gnt = (aw_hs | aw_done_q) & (w_hs | w_done_q);
    assign push   = ar_hs | wr_gnt;
    assign pop    = r_hs | b_hs;
    assign gnt_o  = push;

    always_comb begin
        cnt_d     = cnt_q;
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = pop;
        err_d     = 1'b0;
        rdata_d   = rdata_q;

        if (wr_gnt) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
        end

        if (push) begin
            fifo_d[wptr_q] = wr_gnt;
            wptr_d = (wptr_q + PTR_W'(1)) & PTR_MASK;
        end
        if (pop) begin
            rptr_d = (rptr_q + PTR_W'(1)) & PTR_MASK;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (r_hs) begin
            rdata_d = axi_rdata_i;
            err_d   = axi_rresp_i[1];
        end else if (b_hs) begin
            err_d   = axi_bresp_i[1];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q     <= '0;
            fifo_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else if (cke_i) begin
            cnt_q     <= cnt_d;
            fifo_q    <= fifo_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

`ifdef IOB_IBEX_BRIDGE_INTG_EN
    // Inverted SECDED(39,32) check bits, matching Ibex's data-integrity encoder
    function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
        logic [6:0] c;
        c[0] = ^(d & 32'h2606BD25);
        c[1] = ^(d & 32'hDEBA8050);
        c[2] = ^(d & 32'h413D89AA);
        c[3] = ^(d & 32'h31234ED1);
        c[4] = ^(d & 32'hC2C1323B);
        c[5] = ^(d & 32'h2DCC624C);
        c[6] = ^(d & 32'h98505586);
        return c ^ 7'h2A;
    endfunction

    logic [6:0] intg_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            intg_q <= secded_inv_enc(32'h0);
        end else if (cke_i && r_hs) begin
            intg_q <= secded_inv_enc(axi_rdata_i[31:0]);
        end
    end

    assign rdata_intg_o = intg_q;
`else
    assign rdata_intg_o = 7'b0;
`endif

    // ID, last and low response bits are intentionally ignored
    logic unused_c;
    assign unused_c = ^{axi_bid_i, axi_rid_i, axi_rlast_i, axi_rresp_i[0], axi_bresp_i[0]};

endmodule

// File: tb/tb_iob_ibex_obi2axi_bridge.sv
// Directed bench for iob_ibex_obi2axi_bridge: data-bus instance (MAX_OUTST=2) and a READ_ONLY instance.
module tb_iob_ibex_obi2axi_bridge;

    logic clk = 1'b0;
    logic cke = 1'b1;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Data-bus instance signals
    logic        req = 0, we = 0;
    logic [3:0]  be = 4'hF;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [6:0]  intg;
    logic        awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
    logic        arvalid, arready = 0, rvalid_i = 0, rready, rlast = 1;
    logic [29:0] awaddr, araddr;
    logic [0:0]  awid, arid, bid = '0, rid = '0;
    logic [31:0] wdata_o, rdata_i = '0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;

    iob_ibex_obi2axi_bridge #(.MAX_OUTST(2), .READ_ONLY(1'b0)) u_dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rdata_intg_o(intg), .err_o(err),
        .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr), .axi_awid_o(awid),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata_o), .axi_wstrb_o(wstrb),
        .axi_wlast_o(wlast),
        .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bresp_i(bresp), .axi_bid_i(bid),
        .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr), .axi_arid_o(arid),
        .axi_rvalid_i(rvalid_i), .axi_rready_o(rready), .axi_rdata_i(rdata_i), .axi_rresp_i(rresp),
        .axi_rid_i(rid), .axi_rlast_i(rlast)
    );

    // Instruction-bus (read-only) instance signals
    logic        ro_req = 0, ro_we = 0;
    logic        ro_gnt, ro_rvalid, ro_err;
    logic [31:0] ro_rdata;
    logic [6:0]  ro_intg;
    logic        ro_awvalid, ro_wvalid, ro_wlast, ro_bready, ro_arvalid, ro_rready;
    logic        ro_arready = 0, ro_bvalid = 0, ro_rvalid_i = 0;
    logic [29:0] ro_awaddr, ro_araddr;
    logic [0:0]  ro_awid, ro_arid;
    logic [31:0] ro_wdata_o, ro_rdata_i = '0;
    logic [3:0]  ro_wstrb;

    iob_ibex_obi2axi_bridge #(.MAX_OUTST(2), .READ_ONLY(1'b1)) u_ro (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .req_i(ro_req), .we_i(ro_we), .be_i(4'hF), .addr_i(30'h40), .wdata_i(32'h0),
        .gnt_o(ro_gnt), .rvalid_o(ro_rvalid), .rdata_o(ro_rdata), .rdata_intg_o(ro_intg),
        .err_o(ro_err),
        .axi_awvalid_o(ro_awvalid), .axi_awready_i(1'b1), .axi_awaddr_o(ro_awaddr),
        .axi_awid_o(ro_awid),
        .axi_wvalid_o(ro_wvalid), .axi_wready_i(1'b1), .axi_wdata_o(ro_wdata_o),
        .axi_wstrb_o(ro_wstrb), .axi_wlast_o(ro_wlast),
        .axi_bvalid_i(ro_bvalid), .axi_bready_o(ro_bready), .axi_bresp_i(2'b00), .axi_bid_i(1'b0),
        .axi_arvalid_o(ro_arvalid), .axi_arready_i(ro_arready), .axi_araddr_o(ro_araddr),
        .axi_arid_o(ro_arid),
        .axi_rvalid_i(ro_rvalid_i), .axi_rready_o(ro_rready), .axi_rdata_i(ro_rdata_i),
        .axi_rresp_i(2'b00), .axi_rid_i(1'b0), .axi_rlast_i(1'b1)
    );

`ifdef IOB_IBEX_BRIDGE_INTG_EN
    localparam logic [6:0] INTG_ZERO = 7'h2A;
`else
    localparam logic [6:0] INTG_ZERO = 7'h00;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        check("rst_intg", 32'(intg), 32'(INTG_ZERO));
        arst = 1'b0;
        tick();

        // Single read
        req = 1; we = 0; addr = 30'h0400_0001; arready = 1;
        #1;
        check("rd_arvalid", 32'(arvalid), 32'd1);
        check("rd_araddr", 32'(araddr), 32'h0400_0001);
        check("rd_gnt", 32'(gnt), 32'd1);
        tick();
        req = 0; arready = 0; rvalid_i = 1; rdata_i = 32'hDEADBEEF; rresp = 2'b00;
        #1;
        check("rd_rready", 32'(rready), 32'd1);
        check("rd_rvalid_lat", 32'(rvalid), 32'd0);
        tick();
        rvalid_i = 0;
        check("rd_rvalid", 32'(rvalid), 32'd1);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_err", 32'(err), 32'd0);
        tick();
        check("rd_rvalid_pulse", 32'(rvalid), 32'd0);

        // Split write: AW at cycle 0, W at cycle 3
        req = 1; we = 1; be = 4'b0011; wdata = 32'h1234; addr = 30'h100; awready = 1; wready = 0;
        #1;
        check("wr_c0_awvalid", 32'(awvalid), 32'd1);
        check("wr_c0_gnt", 32'(gnt), 32'd0);
        check("wr_wstrb", 32'(wstrb), 32'h3);
        tick();
        awready = 0;
        #1;
        check("wr_c1_awvalid", 32'(awvalid), 32'd0);
        check("wr_c1_wvalid", 32'(wvalid), 32'd1);
        check("wr_c1_gnt", 32'(gnt), 32'd0);
        tick();
        tick();
        wready = 1;
        #1;
        check("wr_c3_gnt", 32'(gnt), 32'd1);
        check("wr_c3_awvalid", 32'(awvalid), 32'd0);
        check("wr_wlast", 32'(wlast), 32'd1);
        check("wr_wdata", wdata_o, 32'h1234);
        tick();
        req = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        #1;
        check("wr_bready", 32'(bready), 32'd1);
        tick();
        bvalid = 0; bresp = 2'b00;
        check("wr_rvalid", 32'(rvalid), 32'd1);
        check("wr_err", 32'(err), 32'd1);
        check("wr_rdata_hold", rdata, 32'hDEADBEEF);
        tick();

        // Outstanding limit
        req = 1; we = 0; be = 4'hF; addr = 30'h200; arready = 1;
        #1;
        check("ol_gnt1", 32'(gnt), 32'd1);
        tick();
        check("ol_gnt2", 32'(gnt), 32'd1);
        tick();
        check("ol_full_arvalid", 32'(arvalid), 32'd0);
        check("ol_full_gnt", 32'(gnt), 32'd0);
        rvalid_i = 1; rdata_i = 32'h1111_1111;
        #1;
        check("ol_retire_rready", 32'(rready), 32'd1);
        check("ol_retire_gnt", 32'(gnt), 32'd0);
        tick();
        rvalid_i = 0;
        #1;
        check("ol_gnt3", 32'(gnt), 32'd1);
        check("ol_rvalid1", 32'(rvalid), 32'd1);
        check("ol_rdata1", rdata, 32'h1111_1111);
        tick();
        req = 0; arready = 0; rvalid_i = 1; rdata_i = 32'h2222_2222;
        tick();
        rdata_i = 32'h3333_3333;
        #1;
        check("ol_rdata2", rdata, 32'h2222_2222);
        tick();
        rvalid_i = 0;
        #1;
        check("ol_rdata3", rdata, 32'h3333_3333);
        check("ol_empty_rready", 32'(rready), 32'd0);

        // Ordering: write then read, R offered before B
        req = 1; we = 1; wdata = 32'h5555; awready = 1; wready = 1;
        #1;
        check("ord_wr_gnt", 32'(gnt), 32'd1);
        tick();
        awready = 0; wready = 0; we = 0; arready = 1;
        #1;
        check("ord_rd_gnt", 32'(gnt), 32'd1);
        tick();
        req = 0; arready = 0; rvalid_i = 1; rdata_i = 32'hCAFE_F00D;
        #1;
        check("ord_rready_blocked", 32'(rready), 32'd0);
        tick();
        check("ord_no_rvalid", 32'(rvalid), 32'd0);
        bvalid = 1; bresp = 2'b00;
        #1;
        check("ord_bready", 32'(bready), 32'd1);
        check("ord_rready_still", 32'(rready), 32'd0);
        tick();
        bvalid = 0;
        #1;
        check("ord_wr_rvalid", 32'(rvalid), 32'd1);
        check("ord_wr_err", 32'(err), 32'd0);
        check("ord_wr_rdata_hold", rdata, 32'h3333_3333);
        check("ord_rready_now", 32'(rready), 32'd1);
        tick();
        rvalid_i = 0;
        #1;
        check("ord_rd_rvalid", 32'(rvalid), 32'd1);
        check("ord_rd_rdata", rdata, 32'hCAFE_F00D);

        // Streaming reads at one outstanding: push and pop every cycle
        req = 1; we = 0; arready = 1;
        tick();
        rvalid_i = 1;
        for (int k = 0; k < 10; k++) begin
            rdata_i = 32'hA000_0000 + 32'(k);
            #1;
            check("st_gnt", 32'(gnt), 32'd1);
            check("st_rready", 32'(rready), 32'd1);
            tick();
            check("st_rvalid", 32'(rvalid), 32'd1);
            check("st_rdata", rdata, 32'hA000_0000 + 32'(k));
        end
        req = 0; arready = 0; rdata_i = 32'hBBBB_0000;
        tick();
        rvalid_i = 0;
        #1;
        check("st_last_rdata", rdata, 32'hBBBB_0000);
        check("st_drained", 32'(rready), 32'd0);

        // Read-only instance: a write request becomes a read
        ro_req = 1; ro_we = 1; ro_arready = 1;
        #1;
        check("ro_arvalid", 32'(ro_arvalid), 32'd1);
        check("ro_gnt", 32'(ro_gnt), 32'd1);
        check("ro_aw_w", 32'({ro_awvalid, ro_wvalid}), 32'd0);
        tick();
        ro_req = 0; ro_arready = 0; ro_rvalid_i = 1; ro_rdata_i = 32'h0; ro_bvalid = 1;
        #1;
        check("ro_bready", 32'(ro_bready), 32'd0);
        check("ro_rready", 32'(ro_rready), 32'd1);
        tick();
        ro_rvalid_i = 0; ro_bvalid = 0;
        check("ro_rvalid", 32'(ro_rvalid), 32'd1);
        check("ro_rdata", ro_rdata, 32'h0);
        check("ro_intg", 32'(ro_intg), 32'(INTG_ZERO));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
